// File: rtl/ss_bus_sequencer_pkg.sv
// Savestate bus sequencer shared definitions: bus/data widths, the parked
// (idle) bus address, the sequencer state encoding and the checksum helper.
package ss_addresses;

    localparam int SS_BUS_WIDTH  = 16;
    localparam int SS_DATA_WIDTH = 32;

    // All ones: no responder decodes this address, so parking here makes
    // every responder see an address change on the next real access.
    localparam logic [SS_BUS_WIDTH-1:0] SS_IDLE_ADDR = {SS_BUS_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SAVE_HOLD = 3'd1,
        SAVE_EMIT = 3'd2,
        LOAD_WAIT = 3'd3,
        LOAD_HOLD = 3'd4,
        FINISH    = 3'd5
    } ss_seq_state_t;

    // Running checksum step: plain 32-bit sum, wrapping mod 2^32.
    function automatic logic [31:0] ss_sum_add(input logic [31:0] acc,
                                               input logic [31:0] word);
        return acc + word;
    endfunction

endpackage

// File: rtl/ss_bus_sequencer_if.sv
// Savestate bus sequencer signal bundle: host save/load streams plus the
// savestate bus itself. master = sequencer, slave = host bridge + responders.
interface ss_bus_sequencer_if;
    import ss_addresses::*;

    logic [SS_DATA_WIDTH-1:0] save_data;
    logic                     save_valid;
    logic                     save_ready;
    logic [SS_DATA_WIDTH-1:0] load_data;
    logic                     load_valid;
    logic                     load_ready;
    logic [SS_BUS_WIDTH-1:0]  bus_addr;
    logic                     bus_wren;
    logic [SS_DATA_WIDTH-1:0] bus_in;
    logic [SS_DATA_WIDTH-1:0] bus_out;

    modport master (
        output save_data, save_valid, input save_ready,
        input  load_data, load_valid, output load_ready,
        output bus_addr, bus_wren, bus_in,
        input  bus_out
    );

    modport slave (
        input  save_data, save_valid, output save_ready,
        output load_data, load_valid, input load_ready,
        input  bus_addr, bus_wren, bus_in,
        output bus_out
    );

endinterface

// File: rtl/ss_bus_sequencer_settle_counter.sv
// Settle counter: after a start pulse, counts CYCLES clock cycles and pulses
// `expired` during the last of them. `running` is high for the whole window.
// A start while running restarts the window.
module ss_settle_counter #(
    parameter int CYCLES = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    output logic expired,
    output logic running
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CW-1:0] cnt_q;
    logic          expired_q;
    logic          running_q;

    // Down-counter with a registered pulse flagged one cycle before wrap-out.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q     <= CW'(0);
            expired_q <= 1'b0;
            running_q <= 1'b0;
        end else if (start) begin
            cnt_q     <= CW'(CYCLES - 1);
            running_q <= 1'b1;
            expired_q <= (CYCLES == 1) ? 1'b1 : 1'b0;
        end else if (running_q) begin
            if (cnt_q == CW'(0)) begin
                running_q <= 1'b0;
                expired_q <= 1'b0;
            end else begin
                cnt_q     <= cnt_q - CW'(1);
                expired_q <= (cnt_q == CW'(1));
            end
        end else begin
            expired_q <= 1'b0;
        end
    end

    assign expired = expired_q;
    assign running = running_q;

endmodule

// File: rtl/ss_bus_sequencer.sv
// Savestate bus master. Walks SS_BASE_ADDR .. SS_BASE_ADDR+SS_WORD_COUNT-1,
// holding each address SETTLE_CYCLES cycles. Save: capture bus_out and
// stream it to the host. Load: take a host word, write it with bus_wren held
// for the full window, park the bus at SS_IDLE_ADDR between words.
// Optional feature macro: SS_SEQ_CHECKSUM_EN adds a 32-bit additive checksum
// trailer word in both directions and the checksum_error output.
module ss_bus_sequencer
    import ss_addresses::*;
#(
    parameter int SS_BASE_ADDR  = 0,
    parameter int SS_WORD_COUNT = 16,
    parameter int SETTLE_CYCLES = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start_save,
    input  logic                 start_load,
    output logic                 busy,
    output logic                 done,
    ss_bus_sequencer_if.master   bus
`ifdef SS_SEQ_CHECKSUM_EN
    ,
    output logic                 checksum_error
`endif
);

    localparam int IDX_W = $clog2(SS_WORD_COUNT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SS_WORD_COUNT - 1);

`ifdef SS_SEQ_CHECKSUM_EN
    localparam bit CKSUM_EN = 1'b1;
`else
    localparam bit CKSUM_EN = 1'b0;
`endif

    // Configuration sanity: the walked range must stay below the park address.
    if (SS_WORD_COUNT < 1) begin : g_bad_word_count
        $error("ss_bus_sequencer: SS_WORD_COUNT must be >= 1");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("ss_bus_sequencer: SETTLE_CYCLES must be >= 1");
    end
    if (SS_BASE_ADDR + SS_WORD_COUNT >= int'(SS_IDLE_ADDR)) begin : g_bad_range
        $error("ss_bus_sequencer: address range reaches SS_IDLE_ADDR");
    end

    ss_seq_state_t            state_q;
    logic [IDX_W-1:0]         idx_q;
    logic [SS_BUS_WIDTH-1:0]  bus_addr_q;
    logic                     bus_wren_q;
    logic [SS_DATA_WIDTH-1:0] bus_in_q;
    logic [SS_DATA_WIDTH-1:0] save_data_q;
    logic                     save_valid_q;
    logic                     load_ready_q;
    logic                     busy_q;
    logic                     done_q;
    logic [31:0]              sum_q;
    logic                     trailer_q;
`ifdef SS_SEQ_CHECKSUM_EN
    logic                     cks_err_q;
`endif

    logic             save_hs_s;
    logic             load_hs_s;
    logic             last_idx_s;
    logic             settle_start_s;
    logic             settle_exp_s;
    logic             settle_run_s;
    logic             settle_done_s;
    logic [IDX_W-1:0] idx_nxt_s;

    function automatic logic [SS_BUS_WIDTH-1:0] addr_of(input logic [IDX_W-1:0] idx);
        return SS_BUS_WIDTH'(SS_BASE_ADDR) + SS_BUS_WIDTH'(idx);
    endfunction

    ss_settle_counter #(
        .CYCLES (SETTLE_CYCLES)
    ) u_settle (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (settle_start_s),
        .expired (settle_exp_s),
        .running (settle_run_s)
    );

    // Handshake decode and settle-window launch on entry to either HOLD state.
    always_comb begin
        save_hs_s     = save_valid_q & bus.save_ready;
        load_hs_s     = load_ready_q & bus.load_valid;
        last_idx_s    = (idx_q == LAST_IDX);
        idx_nxt_s     = idx_q + IDX_W'(1);
        settle_done_s = settle_exp_s & settle_run_s;
        case (state_q)
            IDLE:      settle_start_s = start_save;
            SAVE_EMIT: settle_start_s = save_hs_s & ~last_idx_s & ~trailer_q;
            LOAD_WAIT: settle_start_s = load_hs_s & ~trailer_q;
            default:   settle_start_s = 1'b0;
        endcase
    end

    // Sequencer FSM with all externally visible outputs registered.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            idx_q        <= IDX_W'(0);
            bus_addr_q   <= SS_IDLE_ADDR;
            bus_wren_q   <= 1'b0;
            bus_in_q     <= {SS_DATA_WIDTH{1'b0}};
            save_data_q  <= {SS_DATA_WIDTH{1'b0}};
            save_valid_q <= 1'b0;
            load_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sum_q        <= 32'h0000_0000;
            trailer_q    <= 1'b0;
`ifdef SS_SEQ_CHECKSUM_EN
            cks_err_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    bus_addr_q <= SS_IDLE_ADDR;
                    bus_wren_q <= 1'b0;
                    if (start_save || start_load) begin
                        idx_q     <= IDX_W'(0);
                        busy_q    <= 1'b1;
                        sum_q     <= 32'h0000_0000;
                        trailer_q <= 1'b0;
`ifdef SS_SEQ_CHECKSUM_EN
                        cks_err_q <= 1'b0;
`endif
                    end
                    if (start_save) begin
                        state_q    <= SAVE_HOLD;
                        bus_addr_q <= addr_of(IDX_W'(0));
                    end else if (start_load) begin
                        state_q      <= LOAD_WAIT;
                        load_ready_q <= 1'b1;
                    end
                end
                SAVE_HOLD: begin
                    if (settle_done_s) begin
                        save_data_q  <= bus.bus_out;
                        save_valid_q <= 1'b1;
                        sum_q        <= ss_sum_add(sum_q, bus.bus_out);
                        state_q      <= SAVE_EMIT;
                    end
                end
                SAVE_EMIT: begin
                    if (save_hs_s) begin
                        if (trailer_q || (last_idx_s && !CKSUM_EN)) begin
                            state_q      <= FINISH;
                            done_q       <= 1'b1;
                            busy_q       <= 1'b0;
                            save_valid_q <= 1'b0;
                            bus_addr_q   <= SS_IDLE_ADDR;
                        end else if (last_idx_s) begin
                            // Data done: present the checksum as one more word.
                            save_data_q <= sum_q;
                            trailer_q   <= 1'b1;
                        end else begin
                            idx_q        <= idx_nxt_s;
                            bus_addr_q   <= addr_of(idx_nxt_s);
                            save_valid_q <= 1'b0;
                            state_q      <= SAVE_HOLD;
                        end
                    end
                end
                LOAD_WAIT: begin
                    bus_addr_q <= SS_IDLE_ADDR;
                    if (load_hs_s) begin
                        load_ready_q <= 1'b0;
                        if (trailer_q) begin
`ifdef SS_SEQ_CHECKSUM_EN
                            cks_err_q <= (bus.load_data != sum_q);
`endif
                            state_q <= FINISH;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            // Address, strobe and data go out together.
                            bus_in_q   <= bus.load_data;
                            bus_addr_q <= addr_of(idx_q);
                            bus_wren_q <= 1'b1;
                            sum_q      <= ss_sum_add(sum_q, bus.load_data);
                            state_q    <= LOAD_HOLD;
                        end
                    end
                end
                LOAD_HOLD: begin
                    if (settle_done_s) begin
                        bus_wren_q <= 1'b0;
                        bus_addr_q <= SS_IDLE_ADDR;
                        idx_q      <= idx_nxt_s;
                        if (last_idx_s && !CKSUM_EN) begin
                            state_q <= FINISH;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            if (last_idx_s) begin
                                trailer_q <= 1'b1;
                            end
                            load_ready_q <= 1'b1;
                            state_q      <= LOAD_WAIT;
                        end
                    end
                end
                FINISH: begin
                    bus_addr_q <= SS_IDLE_ADDR;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign bus.save_data  = save_data_q;
    assign bus.save_valid = save_valid_q;
    assign bus.load_ready = load_ready_q;
    assign bus.bus_addr   = bus_addr_q;
    assign bus.bus_wren   = bus_wren_q;
    assign bus.bus_in     = bus_in_q;
`ifdef SS_SEQ_CHECKSUM_EN
    assign checksum_error = cks_err_q;
`endif

endmodule

// File: tb/tb_ss_bus_sequencer.sv
// Scoreboard bench for ss_bus_sequencer: save words expected from the stub
// responder contents, load writes expected from the host word list.
module tb_ss_bus_sequencer;
    import ss_addresses::*;

    localparam int WC     = 4;
    localparam int SC     = 10;
    localparam int BUDGET = 2000;
    localparam logic [SS_BUS_WIDTH-1:0] IDLE_A = SS_IDLE_ADDR;

    logic clk = 1'b0;
    logic reset_n;
    logic start_save;
    logic start_load;
    logic busy;
    logic done;
`ifdef SS_SEQ_CHECKSUM_EN
    logic checksum_error;
`endif

    ss_bus_sequencer_if bus_if ();

    ss_bus_sequencer #(
        .SS_BASE_ADDR  (0),
        .SS_WORD_COUNT (WC),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_save (start_save),
        .start_load (start_load),
        .busy       (busy),
        .done       (done),
        .bus        (bus_if)
`ifdef SS_SEQ_CHECKSUM_EN
        ,
        .checksum_error (checksum_error)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Stub responders: read table for saves, memory captured by writes.
    logic [31:0] resp_tbl [WC];
    logic [31:0] mem      [WC];

    always_comb begin
        if (bus_if.bus_addr < 16'(WC)) bus_if.bus_out = resp_tbl[bus_if.bus_addr[1:0]];
        else                           bus_if.bus_out = 32'h0;
    end

    always @(posedge clk) begin
        if (bus_if.bus_wren && bus_if.bus_addr < 16'(WC))
            mem[bus_if.bus_addr[1:0]] <= bus_if.bus_in;
    end

    // Scoreboard queues (address -1 = not checked).
    logic [31:0] exp_save_q  [$];
    int          exp_saddr_q [$];
    logic [31:0] exp_wdata_q [$];
    int          exp_waddr_q [$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string p);
        check32({p, "_bus_addr"},   32'(bus_if.bus_addr),   32'(IDLE_A));
        check32({p, "_bus_wren"},   32'(bus_if.bus_wren),   32'd0);
        check32({p, "_bus_in"},     bus_if.bus_in,          32'd0);
        check32({p, "_save_data"},  bus_if.save_data,       32'd0);
        check32({p, "_save_valid"}, 32'(bus_if.save_valid), 32'd0);
        check32({p, "_load_ready"}, 32'(bus_if.load_ready), 32'd0);
        check32({p, "_busy"},       32'(busy),              32'd0);
        check32({p, "_done"},       32'(done),              32'd0);
    endtask

    // Monitor: pops expectations whenever the DUT presents a word or a write.
    logic prev_wren = 1'b0;
    int   wren_run  = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_wren = 1'b0;
            wren_run  = 0;
        end else begin
            if (bus_if.save_valid) begin
                if (exp_save_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL save_extra: got 0x%08h want no word", bus_if.save_data);
                end else begin
                    if (exp_saddr_q[0] >= 0)
                        check32("save_addr", 32'(bus_if.bus_addr), 32'(exp_saddr_q[0]));
                    check32("save_data", bus_if.save_data, exp_save_q[0]);
                    if (bus_if.save_ready) begin
                        void'(exp_save_q.pop_front());
                        void'(exp_saddr_q.pop_front());
                    end
                end
            end
            if (bus_if.bus_wren) begin
                if (!prev_wren) begin
                    if (exp_wdata_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL wr_extra: got addr 0x%04h want no write", bus_if.bus_addr);
                    end else begin
                        check32("wr_addr", 32'(bus_if.bus_addr), 32'(exp_waddr_q.pop_front()));
                        check32("wr_data", bus_if.bus_in, exp_wdata_q.pop_front());
                    end
                end
                wren_run++;
            end else if (prev_wren) begin
                check32("wren_len", 32'(wren_run), 32'(SC));
                wren_run = 0;
            end
            prev_wren = bus_if.bus_wren;
        end
    end

    // bp_mode: 0 always ready, 1 random ready, 2 stall word 1 for 7 cycles.
    task automatic do_save(input int bp_mode, input bit both_start, input bit mid_load);
        logic [31:0] s = 32'h0;
        int cyc = 1, stall = 0, lr_cnt = 0;
        bit first = 1'b1, done_seen = 1'b0, hs_prev = 1'b0;
        for (int i = 0; i < WC; i++) begin
            exp_save_q.push_back(resp_tbl[i]);
            exp_saddr_q.push_back(i);
            s = s + resp_tbl[i];
        end
`ifdef SS_SEQ_CHECKSUM_EN
        exp_save_q.push_back(s);
        exp_saddr_q.push_back(-1);
`endif
        start_save = 1'b1;
        start_load = both_start;
        tick();
        start_save = 1'b0;
        start_load = 1'b0;
        check32("save_busy", 32'(busy), 32'd1);
        while (!done_seen && cyc < BUDGET) begin
            if (done) begin
                done_seen = 1'b1;
                check32("done_after_hs", 32'(hs_prev), 32'd1);
                check32("busy_at_done", 32'(busy), 32'd0);
            end else begin
                if (bus_if.save_valid && first) begin
                    check32("save_latency", 32'(cyc), 32'(SC + 1));
                    first = 1'b0;
                end
                if (bus_if.load_ready) lr_cnt++;
                case (bp_mode)
                    1: bus_if.save_ready = 1'($urandom_range(0, 1));
                    2: begin
                        if (bus_if.save_valid && bus_if.bus_addr == 16'd1 && stall < 7) begin
                            bus_if.save_ready = 1'b0;
                            stall++;
                        end else begin
                            bus_if.save_ready = 1'b1;
                        end
                    end
                    default: bus_if.save_ready = 1'b1;
                endcase
                start_load = (mid_load && cyc == 5);
                hs_prev = bus_if.save_valid && bus_if.save_ready;
                tick();
                cyc++;
            end
        end
        start_load = 1'b0;
        bus_if.save_ready = 1'b0;
        if (!done_seen) begin
            total++; bad++;
            $display("FAIL save_timeout: got no done want done within %0d cycles", BUDGET);
        end
        tick();
        check32("done_pulse", 32'(done), 32'd0);
        check32("save_idle_addr", 32'(bus_if.bus_addr), 32'(IDLE_A));
        check32("save_count_left", 32'(exp_save_q.size()), 32'd0);
        check32("ignored_load", 32'(lr_cnt + int'(bus_if.load_ready)), 32'd0);
        exp_save_q.delete();
        exp_saddr_q.delete();
    endtask

    task automatic do_load(input logic [31:0] words [WC], input logic [31:0] trailer,
                           input int gap_mode, input bit rst_mid);
        logic [31:0] tx [$];
        logic [31:0] s = 32'h0;
        int cyc = 1, h2 = 0;
        bit done_seen = 1'b0, aborted = 1'b0, hs_prev = 1'b0;
        for (int i = 0; i < WC; i++) begin
            tx.push_back(words[i]);
            exp_wdata_q.push_back(words[i]);
            exp_waddr_q.push_back(i);
            s = s + words[i];
        end
`ifdef SS_SEQ_CHECKSUM_EN
        tx.push_back(trailer);
`endif
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
        check32("load_busy", 32'(busy), 32'd1);
        while (!done_seen && !aborted && cyc < BUDGET) begin
            if (done) begin
                done_seen = 1'b1;
                check32("load_busy_at_done", 32'(busy), 32'd0);
            end else begin
                if (rst_mid && bus_if.bus_wren && bus_if.bus_addr == 16'd2) h2++;
                if (rst_mid && h2 == 3) begin
                    reset_n = 1'b0;
                    bus_if.load_valid = 1'b0;
                    tick();
                    check_idle_outputs("rst_mid");
                    reset_n = 1'b1;
                    exp_wdata_q.delete();
                    exp_waddr_q.delete();
                    aborted = 1'b1;
                end else begin
                    if (tx.size() > 0 && (gap_mode == 0 || $urandom_range(0, 2) != 0)) begin
                        bus_if.load_valid = 1'b1;
                        bus_if.load_data  = tx[0];
                    end else begin
                        bus_if.load_valid = 1'b0;
                        bus_if.load_data  = $urandom;
                    end
                    hs_prev = bus_if.load_valid && bus_if.load_ready;
                    tick();
                    if (hs_prev) void'(tx.pop_front());
                    cyc++;
                end
            end
        end
        bus_if.load_valid = 1'b0;
        if (!done_seen && !aborted) begin
            total++; bad++;
            $display("FAIL load_timeout: got no done want done within %0d cycles", BUDGET);
        end
        if (!aborted) begin
            check32("load_consumed", 32'(tx.size()), 32'd0);
            check32("load_writes_left", 32'(exp_wdata_q.size()), 32'd0);
            for (int i = 0; i < WC; i++) check32("load_mem", mem[i], words[i]);
`ifdef SS_SEQ_CHECKSUM_EN
            check32("checksum_error", 32'(checksum_error), 32'(trailer != s));
`endif
            tick();
            check32("load_idle_addr", 32'(bus_if.bus_addr), 32'(IDLE_A));
        end
        exp_wdata_q.delete();
        exp_waddr_q.delete();
    endtask

    logic [31:0] words [WC];
    logic [31:0] wsum;

    initial begin
        reset_n = 1'b0;
        start_save = 1'b0;
        start_load = 1'b0;
        bus_if.save_ready = 1'b0;
        bus_if.load_valid = 1'b0;
        bus_if.load_data  = 32'h0;
        for (int i = 0; i < WC; i++) begin
            resp_tbl[i] = 32'hA000_0000 + 32'(i);
            mem[i] = 32'h0;
        end
        repeat (3) tick();
        check_idle_outputs("reset");
        reset_n = 1'b1;
        tick();

        do_save(0, 1'b0, 1'b0);
        do_save(2, 1'b0, 1'b0);

        words = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        do_load(words, 32'hAAAA_AAAA, 0, 1'b0);

        do_save(0, 1'b1, 1'b1);

        words = '{32'h5555_0000, 32'h5555_0001, 32'h5555_0002, 32'h5555_0003};
        do_load(words, 32'h0, 0, 1'b1);
        tick();

`ifdef SS_SEQ_CHECKSUM_EN
        for (int i = 0; i < WC; i++) resp_tbl[i] = 32'h0000_0001;
        do_save(0, 1'b0, 1'b0);
        words = '{32'h1, 32'h1, 32'h1, 32'h1};
        do_load(words, 32'h0000_0005, 0, 1'b0);
        do_load(words, 32'h0000_0004, 0, 1'b0);
`endif

        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < WC; i++) resp_tbl[i] = $urandom;
            do_save(1, 1'b0, 1'b0);
            wsum = 32'h0;
            for (int i = 0; i < WC; i++) begin
                words[i] = $urandom;
                wsum = wsum + words[i];
            end
            do_load(words, ($urandom_range(0, 1) == 0) ? wsum : wsum ^ 32'h0000_0100, 1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ss_bus_sequencer.md
# ss_bus_sequencer

Savestate bus master that walks the savestate address space one bus word at a time. It drives `bus_addr`/`bus_wren`/`bus_in` to every savestate responder (register and memory bridges) and collects their `bus_out`. On save it streams words out to the host bridge; on load it streams words in from the host bridge. It sits between the host/bridge interface and the savestate bus.

## Interface
Parameters:
- `SS_BASE_ADDR`, 0: first bus address visited.
- `SS_WORD_COUNT`, 16: number of consecutive bus addresses visited; must be ≥1.
- `SETTLE_CYCLES`, 10: cycles each address is held before capture or release. Must cover the slowest responder; memory bridges need (words per bus + 2).

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `start_save`  in  1  pulse; begin a save when idle.
- `start_load`  in  1  pulse; begin a load when idle.
- `busy`  out  1  high from accepted start until `done`.
- `done`  out  1  one-cycle pulse at completion.
- `save_data`  out  SS_DATA_WIDTH  outgoing word.
- `save_valid`  out  1  `save_data` is valid.
- `save_ready`  in  1  host accepts `save_data`.
- `load_data`  in  SS_DATA_WIDTH  incoming word.
- `load_valid`  in  1  `load_data` is valid.
- `load_ready`  out  1  sequencer accepts `load_data`.
- `bus_addr`  out  SS_BUS_WIDTH  savestate bus address.
- `bus_wren`  out  1  write strobe, held for the full address window.
- `bus_in`  out  SS_DATA_WIDTH  write data to responders.
- `bus_out`  in  SS_DATA_WIDTH  OR of responder read data.

## Operation
- **States:** IDLE, SAVE_HOLD, SAVE_EMIT, LOAD_WAIT, LOAD_HOLD, FINISH.
- **IDLE:**
  - `bus_addr`=SS_IDLE_ADDR (all ones, outside every responder range).
  - `bus_wren`=0.
  - If `start_save`=1, go to SAVE_HOLD. Otherwise, if `start_load`=1, go to LOAD_WAIT. If both are high in the same cycle, save wins.
  - Entering either path sets index=0 and `busy`=1.
- **SAVE_HOLD:**
  - Drive `bus_addr`=SS_BASE_ADDR+index with `bus_wren`=0.
  - Count SETTLE_CYCLES. On the last count, register `bus_out` into `save_data` and go to SAVE_EMIT.
- **SAVE_EMIT:**
  - `save_valid`=1. `bus_addr` is unchanged, so responders sit in their finished state.
  - On `save_valid`&&`save_ready`, increment index. Go to SAVE_HOLD, or to FINISH if this was the last index.
- **LOAD_WAIT:**
  - `bus_addr`=SS_IDLE_ADDR and `load_ready`=1.
  - On `load_valid`&&`load_ready`, latch `load_data` into `bus_in` and go to LOAD_HOLD.
- **LOAD_HOLD:**
  - `bus_addr`=SS_BASE_ADDR+index and `bus_wren`=1. Address, write strobe and data all appear in the same cycle, because responders sample `bus_wren` on the first in-range cycle.
  - After SETTLE_CYCLES, drop `bus_wren`, increment index, and go to LOAD_WAIT, or to FINISH if this was the last index.
- **FINISH:**
  - `bus_addr`=SS_IDLE_ADDR.
  - `done`=1 for one cycle, `busy`=0, then IDLE.
- **Index width:** `$clog2(SS_WORD_COUNT+1)`. The bus address sum is SS_BUS_WIDTH wide and never wraps; elaboration asserts SS_BASE_ADDR+SS_WORD_COUNT < SS_IDLE_ADDR.
- **Starts while busy** are ignored.

## Timing
- **Reset values:** state=IDLE, `bus_addr`=SS_IDLE_ADDR, `bus_wren`=0, `bus_in`=0, `save_data`=0, `save_valid`=0, `load_ready`=0, `busy`=0, `done`=0.
- **Reset mid-operation:** everything returns to reset values in the next cycle. No partial word is emitted.
- **Address changes:** consecutive save addresses differ by 1. Load parks at SS_IDLE_ADDR between words. In both cases responders see the address change they need to restart.
- **Save latency:** first `save_valid` arrives SETTLE_CYCLES+1 cycles after `start_save` is sampled. Per word: SETTLE_CYCLES+1 cycles, plus any backpressure.
- **Load per word:** 1 accept cycle + SETTLE_CYCLES.
- **Output registering:** all outputs are registered. `save_data` is stable while `save_valid`=1 and `save_ready`=0.

## Configuration
- **`SS_SEQ_CHECKSUM_EN` defined:**
  - Adds output `checksum_error` (1 bit, reset 0).
  - Keeps a 32-bit additive sum of all data words, mod 2^32.
  - Save: after the last data word, emits one extra word equal to the sum, then FINISH.
  - Load: consumes one extra word in LOAD_WAIT without a bus write. Sets `checksum_error`=1 if it differs from the sum; the flag holds until the next start or reset.
  - `done` pulses in both cases.
- **Not defined:** exactly SS_WORD_COUNT words move in each direction, and the port is absent.

## Structure
- **Package `ss_addresses`:** holds SS_BUS_WIDTH, SS_DATA_WIDTH, the new constant SS_IDLE_ADDR (all ones), and the typedef `ss_seq_state_t` for the six states.
- **Sub-module `ss_settle_counter`:** parameter CYCLES; inputs `start` and `clk`/`reset_n`; outputs `expired` (one-cycle pulse) and `running`. Used by both HOLD states.

## Test plan
- **Save:** SS_WORD_COUNT=4, SETTLE_CYCLES=10, stub responder returns 0xA0000000+addr, `save_ready`=1. Expect words 0xA0000000..0xA0000003 in order; `done` 1 cycle after the 4th handshake; `bus_addr` back to all ones.
- **Save backpressure:** `save_ready` low for 7 cycles on word 1. `save_data` stays 0xA0000001 and `bus_addr` stays 1; no word is lost or duplicated.
- **Load:** host supplies 0x11111111, 0x22222222, 0x33333333, 0x44444444. A stub memory at addr 0..3 holds exactly those values. `bus_wren` is high for exactly 10 cycles per address, and asserted in the same cycle as the address.
- **Simultaneous starts, and starts while busy:** `start_save`=`start_load`=1 runs a save. A `start_load` pulse mid-save is ignored.
- **Reset mid-load:** `reset_n`=0 during LOAD_HOLD of word 2. The next cycle shows `bus_wren`=0, `bus_addr`=all ones, `busy`=0.
- **`SS_SEQ_CHECKSUM_EN`:** saving 4 words of 0x00000001 emits a 5th word 0x00000004. Loading with a trailer of 0x00000005 raises `checksum_error`=1.
